// File: rtl/capture_fifo_pkg.sv
// capture_pkg: shared defaults for the capture FIFO slice.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default sample and pointer widths
//   DEF_AE_THRESH                   : default almost-empty threshold
//   af_default()                    : default almost-full threshold (DEPTH-4)
//   DROP_CNT_W                      : width of the optional drop counter
package capture_pkg;

    localparam int DEF_DATA_WIDTH = 48;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_AE_THRESH  = 4;
    localparam int DROP_CNT_W     = 16;

    function automatic int af_default(input int aw);
        return (1 << aw) - 4;
    endfunction

endpackage

// File: rtl/capture_fifo_if.sv
// capture_fifo_if: sample/handshake bundle for capture_fifo.
//   master : producer/consumer side (drives data_in, enables, flush, clear_flags)
//   slave  : the FIFO (drives data_out, valid, status flags, fill_count)
// Optional macro CAPTURE_FIFO_DROP_COUNT_EN adds the drop_count signal.
interface capture_fifo_if
    import capture_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  write_enabled;
    logic                  read_enabled;
    logic                  flush;
    logic                  clear_flags;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  overflow;
    logic                  underflow;
    logic [ADDR_WIDTH:0]   fill_count;
`ifdef CAPTURE_FIFO_DROP_COUNT_EN
    logic [DROP_CNT_W-1:0] drop_count;
`endif

    modport master (
        output data_in, write_enabled, read_enabled, flush, clear_flags,
        input  data_out, data_out_valid, fifo_empty, fifo_full,
               almost_empty, almost_full, overflow, underflow, fill_count
`ifdef CAPTURE_FIFO_DROP_COUNT_EN
        , input drop_count
`endif
    );

    modport slave (
        input  data_in, write_enabled, read_enabled, flush, clear_flags,
        output data_out, data_out_valid, fifo_empty, fifo_full,
               almost_empty, almost_full, overflow, underflow, fill_count
`ifdef CAPTURE_FIFO_DROP_COUNT_EN
        , output drop_count
`endif
    );

endinterface

// File: rtl/capture_fifo_ram.sv
// capture_fifo_ram: simple dual-port storage, one write port and one
// registered read port.
//   clk, rst_n : clock, synchronous active-low reset (read register only)
//   we_i, waddr_i, wdata_i : write port
//   re_i, raddr_i          : read request; rdata_o updates one cycle later
//   rdata_o                : read data, held while re_i is low
module capture_fifo_ram #(
    parameter int DW = 48,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    // Array contents are not reset so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)    rdata_q <= '0;
        else if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/capture_fifo.sv
// capture_fifo: synchronous capture FIFO with true full, sticky error flags
// and almost-full/almost-empty status.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : capture_fifo_if.slave (data, enables, flush, clear_flags,
//                data_out/valid, status flags, fill_count)
// Optional macro CAPTURE_FIFO_DROP_COUNT_EN adds a saturating count of
// rejected writes on bus.drop_count.
module capture_fifo
    import capture_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_THRESH  = af_default(ADDR_WIDTH),
    parameter int AE_THRESH  = DEF_AE_THRESH
) (
    input  logic            clk,
    input  logic            rst_n,
    capture_fifo_if.slave   bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  vld_q, ov_q, uf_q;
    logic                  full, empty, wr_acc, rd_acc, ov_set, uf_set;

    // Status comes from the registered count only.
    assign full  = (cnt_q == DEPTH_C);
    assign empty = (cnt_q == '0);

    // Flush masks the cycle's requests, including their error reporting.
    assign wr_acc = bus.write_enabled & ~full  & ~bus.flush;
    assign rd_acc = bus.read_enabled  & ~empty & ~bus.flush;
    assign ov_set = bus.write_enabled &  full  & ~bus.flush;
    assign uf_set = bus.read_enabled  &  empty & ~bus.flush;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            vld_q    <= 1'b0;
            ov_q     <= 1'b0;
            uf_q     <= 1'b0;
        end else begin
            if (bus.flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
                cnt_q <= cnt_d;
            end
            vld_q <= rd_acc;
            // A new error in the same cycle as clear_flags wins.
            ov_q  <= ov_set | (ov_q & ~bus.clear_flags);
            uf_q  <= uf_set | (uf_q & ~bus.clear_flags);
        end
    end

    capture_fifo_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.data_in),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (bus.data_out)
    );

`ifdef CAPTURE_FIFO_DROP_COUNT_EN
    logic [DROP_CNT_W-1:0] drop_q, drop_base;

    // Clear first, then count this cycle's rejection, saturating at all-ones.
    assign drop_base = bus.clear_flags ? '0 : drop_q;

    always_ff @(posedge clk) begin
        if (!rst_n)                        drop_q <= '0;
        else if (ov_set && drop_base != '1) drop_q <= drop_base + 1'b1;
        else                               drop_q <= drop_base;
    end

    assign bus.drop_count = drop_q;
`endif

    assign bus.data_out_valid = vld_q;
    assign bus.fifo_empty     = empty;
    assign bus.fifo_full      = full;
    assign bus.almost_empty   = (cnt_q <= AE_C);
    assign bus.almost_full    = (cnt_q >= AF_C);
    assign bus.overflow       = ov_q;
    assign bus.underflow      = uf_q;
    assign bus.fill_count     = cnt_q;

endmodule
